trivium_stream_xor: RTL and testbench

- Consumer end of the trivium keystream interface. Drives the generator's enable and collects its serial keystream_bit output.
- Packs the bits into keystream bytes and XORs each byte with an incoming data byte under a valid/ready handshake.
- Encryption and decryption are the same operation, so one block serves both directions.
- Sits between the trivium generator and the byte-wide data path. It also owns the generator's warm-up sequencing and re-key restart.

---
 rtl/trivium_pkg.sv | 18 +
 rtl/trivium_ks_packer.sv | 70 +++++++
 rtl/trivium_stream_xor.sv | 144 ++++++++++++++
 tb/tb_trivium_stream_xor.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// Shared definitions for the trivium keystream consumer and generator.
package trivium_pkg;

   // Generator initialisation rounds before the keystream is usable.
   localparam int TRIVIUM_WARMUP = 1152;

   // Default data / keystream word width.
   localparam int TRIVIUM_DATA_W = 8;

   // Consumer sequencing states.
   typedef enum logic [1:0] {
      GENRST = 2'd0,
      WARMUP = 2'd1,
      FILL   = 2'd2,
      HAVE   = 2'd3
   } ks_state_e;

endpackage

// File: rtl/trivium_ks_packer.sv
// Collects the generator's serial keystream into LSB-first words.
// The generator's output is registered, so the bit produced by an enable
// cycle is visible one cycle later; sample_reg carries that one-cycle skew.
module trivium_ks_packer
   import trivium_pkg::*;
#(
   parameter int DATA_W = TRIVIUM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clear,
   input  logic              fire,
   input  logic              ks_bit,
   output logic              last_fire,
   output logic              done,
   output logic [DATA_W-1:0] ks_word
);

   localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

   logic [CW-1:0]     issue_cnt_reg;
   logic [CW-1:0]     bit_cnt_reg;
   logic              sample_reg;
   logic [DATA_W-1:0] word_reg;
   logic [DATA_W-1:0] word_shift;

   // The last enable of a word tells the top to drop ks_enable next cycle.
   assign last_fire = fire && (issue_cnt_reg == LAST);
   // The word is complete as the final skewed sample lands.
   assign done      = sample_reg && (bit_cnt_reg == LAST);
   assign ks_word   = word_reg;

   // New bits enter at the top so the first collected bit ends up in bit 0.
   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_shift
         if (gi == DATA_W - 1) begin : g_top
            assign word_shift[gi] = ks_bit;
         end else begin : g_low
            assign word_shift[gi] = word_reg[gi+1];
         end
      end
   endgenerate

   // Enable counting, enable-to-sample skew and the shift register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         issue_cnt_reg <= '0;
         bit_cnt_reg   <= '0;
         sample_reg    <= 1'b0;
         word_reg      <= '0;
      end else if (clear) begin
         issue_cnt_reg <= '0;
         bit_cnt_reg   <= '0;
         sample_reg    <= 1'b0;
         word_reg      <= '0;
      end else begin
         sample_reg <= fire;
         if (fire) begin
            issue_cnt_reg <= last_fire ? '0 : issue_cnt_reg + 1'b1;
         end
         if (sample_reg) begin
            word_reg    <= word_shift;
            bit_cnt_reg <= done ? '0 : bit_cnt_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/trivium_stream_xor.sv
// Consumer end of the trivium keystream: sequences generator reset and
// warm-up, packs keystream words and XORs them into a byte stream under a
// valid/ready handshake. Encryption and decryption are the same operation.
module trivium_stream_xor
   import trivium_pkg::*;
#(
   parameter int WARMUP_CYCLES = TRIVIUM_WARMUP,
   parameter int DATA_W        = TRIVIUM_DATA_W,
   parameter int CNT_W         = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              restart,
   input  logic              ks_bit,
   output logic              ks_enable,
   output logic              ks_rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic [CNT_W-1:0]  word_count
);

   localparam int WW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
   localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYCLES);

   ks_state_e         state_reg;
   logic [WW-1:0]     warm_cnt_reg;
   logic              ks_rst_reg;
   logic              ks_enable_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic              out_valid_reg;
   logic [CNT_W-1:0]  word_count_reg;

   logic              fire;
   logic              pk_last_fire;
   logic              pk_done;
   logic [DATA_W-1:0] pk_word;
   logic              accept;

   // Only enables issued while filling produce bits that are kept.
   assign fire     = ks_enable_reg && (state_reg == FILL);
   // A restart wins over a coincident accept.
   assign in_ready = (state_reg == HAVE) && !restart && (!out_valid_reg || out_ready);
   assign accept   = in_valid && in_ready;

   assign ks_enable  = ks_enable_reg;
   assign ks_rst     = ks_rst_reg;
   assign out_data   = out_data_reg;
   assign out_valid  = out_valid_reg;
   assign word_count = word_count_reg;
   assign busy       = (state_reg != HAVE);

   trivium_ks_packer #(
      .DATA_W (DATA_W)
   ) u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (restart),
      .fire      (fire),
      .ks_bit    (ks_bit),
      .last_fire (pk_last_fire),
      .done      (pk_done),
      .ks_word   (pk_word)
   );

   // Sequencing FSM with registered generator controls. Warm-up enables run
   // straight into the fill enables; the extra warm-up cycle soaks up the
   // generator's output register so the first kept bit is a fresh one.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= GENRST;
         warm_cnt_reg  <= '0;
         ks_rst_reg    <= 1'b0;
         ks_enable_reg <= 1'b0;
      end else if (restart) begin
         state_reg     <= GENRST;
         warm_cnt_reg  <= '0;
         ks_rst_reg    <= 1'b0;
         ks_enable_reg <= 1'b0;
      end else begin
         case (state_reg)
            GENRST: begin
               state_reg     <= WARMUP;
               warm_cnt_reg  <= '0;
               ks_rst_reg    <= 1'b1;
               ks_enable_reg <= 1'b1;
            end
            WARMUP: begin
               if (warm_cnt_reg == WARM_LAST) begin
                  state_reg    <= FILL;
                  warm_cnt_reg <= '0;
               end else begin
                  warm_cnt_reg <= warm_cnt_reg + 1'b1;
               end
            end
            FILL: begin
               if (pk_last_fire) begin
                  ks_enable_reg <= 1'b0;
               end
               if (pk_done) begin
                  state_reg <= HAVE;
               end
            end
            HAVE: begin
               if (accept) begin
                  state_reg     <= FILL;
                  ks_enable_reg <= 1'b1;
               end
            end
            default: begin
               state_reg     <= GENRST;
               ks_rst_reg    <= 1'b0;
               ks_enable_reg <= 1'b0;
            end
         endcase
      end
   end

   // Output register and word counter; a pending word survives a restart.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_data_reg   <= '0;
         out_valid_reg  <= 1'b0;
         word_count_reg <= '0;
      end else begin
         if (accept) begin
            out_data_reg  <= in_data ^ pk_word;
            out_valid_reg <= 1'b1;
         end else if (out_ready) begin
            out_valid_reg <= 1'b0;
         end
         if (restart) begin
            word_count_reg <= '0;
         end else if (accept) begin
            word_count_reg <= word_count_reg + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_trivium_stream_xor.sv
// Bench for trivium_stream_xor: a generator model that records every bit it
// emits, a scoreboard that derives each output word from the recorded
// keystream (word j uses generator bits KS_START+8j .. KS_START+8j+7), and
// directed phases with literal expectations.
module tb_trivium_stream_xor;

   localparam int KS_START = 1153;      // first kept enable index after reset
   localparam int WARM_EN  = 1153 + 8;  // consecutive enables before first pause

   logic       clk = 1'b0;
   logic       rst, restart, ks_bit;
   logic [7:0] in_data;
   logic       in_valid, out_ready;
   logic       ks_enable, ks_rst, in_ready, out_valid, busy;
   logic [7:0] out_data;
   logic [15:0] word_count;
   logic       ks_enable4, ks_rst4, in_ready4, out_valid4, busy4;
   logic [7:0] out_data4;
   logic [3:0] word_count4;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   trivium_stream_xor dut (
      .clk(clk), .rst(rst), .restart(restart), .ks_bit(ks_bit),
      .ks_enable(ks_enable), .ks_rst(ks_rst), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
      .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
      .word_count(word_count)
   );

   trivium_stream_xor #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .restart(restart), .ks_bit(ks_bit),
      .ks_enable(ks_enable4), .ks_rst(ks_rst4), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready4), .out_data(out_data4),
      .out_valid(out_valid4), .out_ready(out_ready), .busy(busy4),
      .word_count(word_count4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- generator model ----------------
   int   mode;
   int   gen_n;
   logic hist [0:4095];

   function automatic logic pat(input int n, input int m);
      logic [31:0] h;
      case (m)
         1: return 1'b1;
         2: return (n >= KS_START) && (((n - KS_START) % 8) == 0);
         default: begin
            h = 32'(n) * 32'h9E3779B1;
            return h[16] ^ h[7];
         end
      endcase
   endfunction

   always @(posedge clk) begin
      if (!ks_rst) begin
         gen_n = 0;
         ks_bit <= 1'b0;
      end else if (ks_enable) begin
         if (gen_n < 4096) hist[gen_n] = pat(gen_n, mode);
         ks_bit <= pat(gen_n, mode);
         gen_n++;
      end
   end

   // ---------------- scoreboard / per-cycle compare ----------------
   logic [7:0] exp_q[$];
   int         acc_idx, model_cnt;
   logic       prev_v, prev_r;
   logic [7:0] prev_d;

   function automatic logic [7:0] kw(input int j);
      logic [7:0] w;
      for (int i = 0; i < 8; i++) w[i] = hist[KS_START + 8*j + i];
      return w;
   endfunction

   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         acc_idx   = 0;
         model_cnt = 0;
         prev_v    = 1'b0;
         prev_r    = 1'b0;
      end else begin
         chk("valid_vs_model", 32'(out_valid), 32'(exp_q.size() != 0));
         chk("valid4_vs_model", 32'(out_valid4), 32'(exp_q.size() != 0));
         if (prev_v && !prev_r) chk("hold_data", 32'(out_data), 32'(prev_d));
         chk("word_count", 32'(word_count), 32'(model_cnt % 65536));
         chk("word_count_w4", 32'(word_count4), 32'(model_cnt % 16));
         chk("dut4_ctrl", 32'({ks_rst4, ks_enable4, in_ready4, busy4}),
             32'({ks_rst, ks_enable, in_ready, busy}));
         if (restart) chk("ready_on_restart", 32'(in_ready), 32'd0);
         if (out_valid && !out_ready) chk("ready_when_stalled", 32'(in_ready), 32'd0);
         if (out_valid && out_ready && exp_q.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(exp_q[0]));
            chk("out_data_w4", 32'(out_data4), 32'(exp_q[0]));
            void'(exp_q.pop_front());
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(in_data ^ kw(acc_idx));
            acc_idx++;
            model_cnt++;
         end
         if (restart) begin
            acc_idx   = 0;
            model_cnt = 0;
         end
         prev_v = out_valid;
         prev_r = out_ready;
         prev_d = out_data;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d);
      int t;
      t = 0;
      in_data  = d;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && t < 3000) begin
         @(negedge clk);
         t++;
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0, required 1 (data %0h)", d);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic get_out(output logic [7:0] d);
      int t;
      t = 0;
      @(negedge clk);
      while (!out_valid && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!out_valid) begin
         n_tests++;
         n_fail++;
         $display("FAIL get_out_timeout: out_valid stayed 0, required 1");
      end
      d = out_data;
      @(posedge clk);
      #1;
   endtask

   // Called from inside the GENRST cycle; returns one cycle into HAVE.
   task automatic check_warmup(input string tag);
      int lowc, enc;
      lowc = 0;
      enc  = 0;
      @(negedge clk);
      while (!ks_rst && lowc < 10) begin
         chk("genrst_enable_low", 32'(ks_enable), 32'd0);
         lowc++;
         @(negedge clk);
      end
      chk("genrst_cycles", 32'(lowc), 32'd1);
      while (ks_enable && enc < 5000) begin
         enc++;
         @(negedge clk);
      end
      chk("enable_run", 32'(enc), 32'(WARM_EN));
      chk("ready_last_fill", 32'(in_ready), 32'd0);
      chk("busy_last_fill", 32'(busy), 32'd1);
      @(negedge clk);
      chk("ready_at_have", 32'(in_ready), 32'd1);
      chk("busy_at_have", 32'(busy), 32'd0);
      $display("[TB] warm-up sequence checked (%s)", tag);
      step();
   endtask

   // ---------------- directed phases ----------------
   logic [7:0] pt [16];
   logic [7:0] ct [16];
   logic [7:0] d;

   initial begin
      rst = 1'b0; restart = 1'b0; in_data = '0; in_valid = 1'b0;
      out_ready = 1'b1; mode = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ks_rst", 32'(ks_rst), 32'd0);
      chk("rst_ks_enable", 32'(ks_enable), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd1);
      step();
      rst = 1'b1;
      check_warmup("reset");

      // All-ones keystream, then a single leading 1 to pin bit order.
      send(8'hA5);
      mode = 2;
      get_out(d);
      chk("lit_all_ones", 32'(d), 32'h5A);
      $display("[TB] word A5 -> %02h", d);
      send(8'h00);
      mode = 0;
      get_out(d);
      chk("lit_lsb_first", 32'(d), 32'h01);
      $display("[TB] word 00 -> %02h", d);

      // Downstream stall with a second word waiting.
      out_ready = 1'b0;
      send(8'h3C);
      in_data  = 8'hC3;
      in_valid = 1'b1;
      repeat (20) step();
      chk("stall_ready_low", 32'(in_ready), 32'd0);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_count", 32'(word_count), 32'd3);
      out_ready = 1'b1;
      @(negedge clk);
      chk("drain_accept_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      get_out(d);
      chk("after_stall_count", 32'(word_count), 32'd4);
      $display("[TB] stalled pair released, second word %02h", d);

      // Encrypt 16 bytes, restart, decrypt them again.
      restart = 1'b1; step(); restart = 1'b0;
      check_warmup("restart_encrypt");
      for (int i = 0; i < 16; i++) begin
         pt[i] = 8'(i * 37 + 11);
         send(pt[i]);
         get_out(ct[i]);
         $display("[TB] enc %0d: %02h -> %02h", i, pt[i], ct[i]);
      end
      chk("enc_count", 32'(word_count), 32'd16);
      restart = 1'b1; step(); restart = 1'b0;
      check_warmup("restart_decrypt");
      for (int i = 0; i < 16; i++) begin
         send(ct[i]);
         get_out(d);
         chk("decrypt", 32'(d), 32'(pt[i]));
         $display("[TB] dec %0d: %02h -> %02h", i, ct[i], d);
      end
      chk("dec_count", 32'(word_count), 32'd16);

      // Restart while filling, with an undrained word pending.
      out_ready = 1'b0;
      send(8'h77);
      repeat (5) step();
      restart = 1'b1; step(); restart = 1'b0;
      chk("rs_busy", 32'(busy), 32'd1);
      chk("rs_ks_rst", 32'(ks_rst), 32'd0);
      chk("rs_ks_enable", 32'(ks_enable), 32'd0);
      chk("rs_count", 32'(word_count), 32'd0);
      chk("rs_pending_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      check_warmup("restart_midfill");
      send(8'h5E);
      get_out(d);
      $display("[TB] post-restart word 5E -> %02h", d);

      // Asynchronous reset in the middle of warm-up.
      restart = 1'b1; step(); restart = 1'b0;
      repeat (300) step();
      #2 rst = 1'b0;
      #1;
      chk("arst_ks_rst", 32'(ks_rst), 32'd0);
      chk("arst_ks_enable", 32'(ks_enable), 32'd0);
      chk("arst_out_valid", 32'(out_valid), 32'd0);
      chk("arst_out_data", 32'(out_data), 32'd0);
      chk("arst_word_count", 32'(word_count), 32'd0);
      chk("arst_in_ready", 32'(in_ready), 32'd0);
      chk("arst_busy", 32'(busy), 32'd1);
      step(); step();
      rst = 1'b1;
      check_warmup("reset_midwarmup");

      // 17 words: the 4-bit counter wraps to 1.
      for (int i = 0; i < 17; i++) begin
         send(8'(i));
         get_out(d);
         $display("[TB] wrap %0d: %02h -> %02h", i, 8'(i), d);
      end
      chk("count17", 32'(word_count), 32'd17);
      chk("count4_wrap", 32'(word_count4), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
